// File: rtl/pipe_issue_ctrl.sv
// Issue controller for the four-stage pipeline: buffers instructions in a small FIFO,
// holds the head back on read-after-write hazards against in-flight slots, and counts issues/stalls.
module pipe_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int HAZ_WIN = 3
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rs1,
    input  logic [3:0]  in_rs2,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_func,
    input  logic [7:0]  in_addr,
    input  logic        flush,
    output logic        iss_valid,
    output logic [3:0]  iss_rs1,
    output logic [3:0]  iss_rs2,
    output logic [3:0]  iss_rd,
    output logic [3:0]  iss_func,
    output logic [7:0]  iss_addr,
    output logic        busy,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic [3:0] rd;
        logic [3:0] func;
        logic [7:0] addr;
    } instr_t;

    instr_t            mem [DEPTH];
    logic [AW:0]       wptr, rptr;
    logic [HAZ_WIN-1:0] vld_pipe;
    logic [3:0]        sb_rd [HAZ_WIN];

    instr_t head;
    logic   empty, full, hazard, push, pop, stall;

    assign head     = mem[rptr[AW-1:0]];
    assign empty    = (wptr == rptr);
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign in_ready = !full;
    assign busy     = !empty || (|vld_pipe) || iss_valid;

    // A source that names the head's own destination never blocks it.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (vld_pipe[i] &&
                ((head.rs1 == sb_rd[i] && head.rs1 != head.rd) ||
                 (head.rs2 == sb_rd[i] && head.rs2 != head.rd)))
                hazard = 1'b1;
        end
        hazard = hazard && !empty;
    end

    assign push  = in_valid && !full && !flush;
    assign pop   = !flush && !empty && !hazard;
    assign stall = !flush && hazard;

    always_ff @(posedge clk1) begin
        if (push)
            mem[wptr[AW-1:0]] <= '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            vld_pipe  <= '0;
            for (int i = 0; i < HAZ_WIN; i++) sb_rd[i] <= '0;
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_func  <= '0;
            iss_addr  <= '0;
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (flush)    rptr <= wptr;
            else if (pop) rptr <= rptr + 1'b1;

            // Scoreboard shifts every edge; bubbles enter as invalid slots.
            for (int i = HAZ_WIN - 1; i > 0; i--) begin
                vld_pipe[i] <= vld_pipe[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
            vld_pipe[0] <= pop;
            sb_rd[0]    <= head.rd;

            iss_valid <= pop;
            if (pop) begin
                iss_rs1   <= head.rs1;
                iss_rs2   <= head.rs2;
                iss_rd    <= head.rd;
                iss_func  <= head.func;
                iss_addr  <= head.addr;
                issue_cnt <= issue_cnt + 16'd1;
            end
            if (stall) stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int HAZ_WIN = 3;

    logic        clk1, rst, in_valid, in_ready, flush, iss_valid, busy;
    logic [3:0]  in_rs1, in_rs2, in_rd, in_func;
    logic [7:0]  in_addr;
    logic [3:0]  iss_rs1, iss_rs2, iss_rd, iss_func;
    logic [7:0]  iss_addr;
    logic [15:0] issue_cnt, stall_cnt;

    pipe_issue_ctrl #(.DEPTH(DEPTH), .HAZ_WIN(HAZ_WIN)) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_func(in_func),
        .in_addr(in_addr), .flush(flush), .iss_valid(iss_valid),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_func(iss_func),
        .iss_addr(iss_addr), .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0] rs1, rs2, rd, func;
        logic [7:0] addr;
    } ins_t;

    ins_t        q[$];
    int          sbm[HAZ_WIN];       // rd of in-flight slot, -1 for a bubble
    ins_t        m_iss;
    logic        m_iv;
    logic [15:0] m_ic, m_sc;
    logic [3:0]  rd_log[$];

    function automatic bit reads(input logic [3:0] rs, input ins_t h, input int w);
        return (w >= 0) && (int'(rs) == w) && (rs != h.rd);
    endfunction

    task automatic model_step();
        bit   haz;
        bit   accept;
        int   ne;
        ins_t n;
        if (rst) begin
            q.delete();
            foreach (sbm[i]) sbm[i] = -1;
            m_iss = '{default: '0};
            m_iv = 0; m_ic = 0; m_sc = 0;
            return;
        end
        accept = in_valid && (q.size() < DEPTH);
        n = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, func: in_func, addr: in_addr};
        haz = 0;
        if (q.size() > 0)
            foreach (sbm[i]) if (reads(q[0].rs1, q[0], sbm[i]) || reads(q[0].rs2, q[0], sbm[i])) haz = 1;
        ne = -1;
        if (flush) begin
            q.delete(); m_iv = 0;
        end else if (q.size() == 0) begin
            m_iv = 0;
        end else if (haz) begin
            m_iv = 0; m_sc++;
        end else begin
            m_iss = q.pop_front(); m_iv = 1; m_ic++; ne = int'(m_iss.rd);
        end
        for (int i = HAZ_WIN - 1; i > 0; i--) sbm[i] = sbm[i-1];
        sbm[0] = ne;
        if (!flush && accept) q.push_back(n);
    endtask

    function automatic bit m_busy();
        bit b = (q.size() > 0) || m_iv;
        foreach (sbm[i]) if (sbm[i] >= 0) b = 1;
        return b;
    endfunction

    // Single compare process: advance the model on each edge, check the DUT 1 time unit later.
    always @(posedge clk1) begin
        model_step();
        #1;
        chk("iss_valid", iss_valid, m_iv);
        chk("iss_fields", {iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr},
            {m_iss.rs1, m_iss.rs2, m_iss.rd, m_iss.func, m_iss.addr});
        chk("in_ready", in_ready, q.size() < DEPTH);
        chk("busy", busy, m_busy());
        chk("issue_cnt", issue_cnt, m_ic);
        chk("stall_cnt", stall_cnt, m_sc);
        if (iss_valid) rd_log.push_back(iss_rd);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(); @(negedge clk1); endtask

    task automatic set_in(input logic v, input logic [3:0] a, b, d, f, input logic [7:0] ad);
        in_valid = v; in_rs1 = a; in_rs2 = b; in_rd = d; in_func = f; in_addr = ad;
    endtask

    task automatic do_reset(input int n);
        rst = 1; in_valid = 0; flush = 0;
        repeat (n) tick();
        rst = 0;
    endtask

    task automatic drain(input int n);
        in_valid = 0; flush = 0;
        repeat (n) tick();
    endtask

    logic [4:0]  vpat;
    logic [23:0] rdseq;
    int          waits;
    bit          acc;

    initial begin
        rst = 1; in_valid = 0; flush = 0;
        set_in(0, 0, 0, 0, 0, 0);
        foreach (sbm[i]) sbm[i] = -1;
        m_iv = 0; m_ic = 0; m_sc = 0; m_iss = '{default: '0};
        tick();
        do_reset(2);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_issue_cnt", issue_cnt, 0);

        // Independent stream: three back-to-back pushes issue on consecutive edges.
        set_in(1, 3, 5, 10, 4'd0, 8'd125); tick();
        chk("ind_first_latency", iss_valid, 0);
        set_in(1, 3, 8, 12, 4'd2, 8'd126); tick();
        chk("ind_rd0", {iss_valid, iss_rd}, {1'b1, 4'd10});
        set_in(1, 7, 3, 13, 4'd5, 8'd127); tick();
        chk("ind_rd1", {iss_valid, iss_rd}, {1'b1, 4'd12});
        in_valid = 0; tick();
        chk("ind_rd2", {iss_valid, iss_rd, iss_addr}, {1'b1, 4'd13, 8'd127});
        chk("ind_counts", {issue_cnt, stall_cnt}, {16'd3, 16'd0});
        drain(4);

        // RAW stall: SUB reads ADD's r10 and waits two bubbles.
        do_reset(1);
        set_in(1, 3, 5, 10, 4'd0, 8'd128); tick();
        set_in(1, 3, 8, 12, 4'd2, 8'd129); tick(); vpat[4] = iss_valid;
        set_in(1, 10, 5, 14, 4'd1, 8'd130); tick(); vpat[3] = iss_valid;
        in_valid = 0;
        tick(); vpat[2] = iss_valid;
        tick(); vpat[1] = iss_valid;
        tick(); vpat[0] = iss_valid;
        chk("raw_valid_pattern", vpat, 5'b11001);
        chk("raw_sub_rd", iss_rd, 4'd14);
        chk("raw_stall_cnt", stall_cnt, 16'd2);
        drain(4);

        // Full FIFO: P feeds r1, A is blocked by it while B..D pile up behind.
        do_reset(1);
        rd_log.delete();
        for (int k = 0; k < 6; k++) begin
            set_in(1, (k == 1) ? 4'd1 : 4'd0, 4'd0, 4'(k + 1), 4'd0, 8'(k));
            waits = 0;
            do begin
                acc = in_ready;
                tick();
                waits++;
            end while (!acc && waits < 10);
            if (k == 4) chk("full_in_ready_low", in_ready, 0);
            if (k == 5) chk("full_fifth_held", waits, 2);
        end
        drain(8);
        chk("full_order_len", rd_log.size(), 6);
        rdseq = '0;
        foreach (rd_log[i]) if (i < 6) rdseq = {rdseq[19:0], rd_log[i]};
        chk("full_order", rdseq, 24'h123456);

        // Flush: three queued behind a hazard, flush plus a push on the same edge.
        do_reset(1);
        rd_log.delete();
        set_in(1, 0, 0, 1, 0, 0); tick();
        set_in(1, 1, 1, 2, 0, 1); tick();
        set_in(1, 1, 0, 3, 0, 2); tick();
        set_in(1, 1, 0, 4, 0, 3); tick();
        set_in(1, 0, 0, 5, 0, 4); flush = 1; tick();
        flush = 0; in_valid = 0;
        chk("flush_in_ready", in_ready, 1);
        waits = 0;
        while (busy && waits <= HAZ_WIN + 1) begin tick(); waits++; end
        chk("flush_busy_drops", busy, 0);
        drain(3);
        chk("flush_issue_cnt", issue_cnt, 16'd1);
        chk("flush_nothing_more", rd_log.size(), 1);

        // Counter wrap from 65535.
        force dut.issue_cnt = 16'hFFFF;
        m_ic = 16'hFFFF;
        #1 release dut.issue_cnt;
        set_in(1, 9, 9, 9, 0, 0); tick();
        in_valid = 0; tick();
        chk("wrap_issue_cnt", issue_cnt, 16'd0);
        drain(3);

        // Reset mid-stream with three instructions queued.
        set_in(1, 0, 0, 1, 0, 0); tick();
        set_in(1, 1, 0, 2, 0, 0); tick();
        set_in(1, 0, 0, 3, 0, 0); tick();
        set_in(1, 0, 0, 4, 0, 0); tick();
        do_reset(2);
        tick();
        chk("midrst_iss_valid", iss_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_counts", {issue_cnt, stall_cnt}, 32'd0);
        chk("midrst_busy", busy, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            set_in(($urandom % 4) != 0, 4'($urandom % 6), 4'($urandom % 6), 4'($urandom % 6),
                   4'($urandom), 8'($urandom));
            flush = ($urandom % 40) == 0;
            rst   = ($urandom % 500) == 0;
            tick();
        end
        rst = 0; drain(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
